// File: rtl/run_seq_pkg.sv
// Shared types and default constants for the run sequencer.
// The TIMEOUT state exists only when RUN_SEQUENCER_WATCHDOG_EN is defined.
package run_seq_pkg;

   localparam int START_W_DEF     = 2;
   localparam int TIMEOUT_CYC_DEF = 4096;
   localparam int CNT_W_DEF       = 16;

   // Wide enough for the largest legal START_W (15).
   localparam int START_CNT_W     = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_RUN,
`ifdef RUN_SEQUENCER_WATCHDOG_EN
      ST_DONE,
      ST_TIMEOUT
`else
      ST_DONE
`endif
   } state_t;

endpackage

// File: rtl/run_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear and count enable.
// Clear takes priority over enable; the count sticks at all-ones.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] count
);

   // Count register: clear, otherwise increment until all-ones.
   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en && (count != '1)) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/run_sequencer.sv
// Run sequencer: accepts a host run request, pulses the core start for
// START_W cycles, times the run and reports completion to the host.
// Optional watchdog: define RUN_SEQUENCER_WATCHDOG_EN to enable TIMEOUT.
module run_sequencer
   import run_seq_pkg::*;
#(
   parameter int START_W     = START_W_DEF,
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
   parameter int CNT_W       = CNT_W_DEF
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             req,
   input  logic [1:0]       prog_sel,
   input  logic             core_done,
   output logic             core_start,
   output logic [1:0]       core_prog_sel,
   output logic             busy,
   output logic             host_done,
   output logic             timeout,
   output logic [CNT_W-1:0] cycle_count
);

   state_t                 state;
   state_t                 state_nxt;
   logic [START_CNT_W-1:0] start_cnt;
   logic                   accept;
   logic                   start_last;
   logic                   at_limit;
   logic                   cnt_en;

   assign accept     = (state == ST_IDLE) && req;
   assign start_last = (start_cnt == START_CNT_W'(START_W - 1));

`ifdef RUN_SEQUENCER_WATCHDOG_EN
   assign at_limit = (cycle_count == CNT_W'(TIMEOUT_CYC));
`else
   assign at_limit = 1'b0;
`endif

   // The count freezes on the edge that hits the watchdog limit.
   assign cnt_en = (state == ST_RUN) && !core_done && !at_limit;

   // State register.
   // NOTE: only control and datapath registers take reset; nothing here is a memory.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; req drops and core_done outside RUN are ignored.
   // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:    if (req) state_nxt = ST_START;
         ST_START:   if (start_last) state_nxt = ST_RUN;
         ST_RUN: begin
            if (core_done) begin
               state_nxt = ST_DONE;
`ifdef RUN_SEQUENCER_WATCHDOG_EN
            end else if (at_limit) begin
               state_nxt = ST_TIMEOUT;
`endif
            end
         end
         ST_DONE:    if (!req) state_nxt = ST_IDLE;
`ifdef RUN_SEQUENCER_WATCHDOG_EN
         ST_TIMEOUT: if (!req) state_nxt = ST_IDLE;
`endif
         default:    state_nxt = ST_IDLE;
      endcase
   end

   // Outputs decoded from the state register only.
   always_comb begin
      core_start = (state == ST_START);
      busy       = (state == ST_START) || (state == ST_RUN);
`ifdef RUN_SEQUENCER_WATCHDOG_EN
      host_done  = (state == ST_DONE) || (state == ST_TIMEOUT);
      timeout    = (state == ST_TIMEOUT);
`else
      host_done  = (state == ST_DONE);
      timeout    = 1'b0;
`endif
   end

   // START dwell counter; wraps to zero as START is left.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         start_cnt <= '0;
      end else if (state == ST_START) begin
         start_cnt <= start_last ? '0 : start_cnt + START_CNT_W'(1);
      end
   end

   // Program select is captured on acceptance and held until the next one.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         core_prog_sel <= '0;
      end else if (accept) begin
         core_prog_sel <= prog_sel;
      end
   end

   sat_counter #(
      .W (CNT_W)
   ) u_cycle_cnt (
      .clock (clock),
      .reset (reset),
      .clr   (accept),
      .en    (cnt_en),
      .count (cycle_count)
   );

endmodule

// File: tb/tb_run_sequencer.sv
// Self-checking bench for run_sequencer. Expectations come from a
// run-level model: a run of n busy core cycles ends with min(n, saturation)
// counted, or with a timeout at TIMEOUT_CYC when the watchdog is built in.
module tb_run_sequencer;

   localparam int START_W     = 2;
   localparam int TIMEOUT_CYC = 8;
   localparam int CNT_W       = 4;
   localparam int SAT         = (1 << CNT_W) - 1;
`ifdef RUN_SEQUENCER_WATCHDOG_EN
   localparam bit WD = 1'b1;
`else
   localparam bit WD = 1'b0;
`endif

   logic             clock;
   logic             reset;
   logic             req;
   logic [1:0]       prog_sel;
   logic             core_done;
   logic             core_start;
   logic [1:0]       core_prog_sel;
   logic             busy;
   logic             host_done;
   logic             timeout;
   logic [CNT_W-1:0] cycle_count;

   int checks   = 0;
   int failures = 0;

   run_sequencer #(
      .START_W     (START_W),
      .TIMEOUT_CYC (TIMEOUT_CYC),
      .CNT_W       (CNT_W)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .req           (req),
      .prog_sel      (prog_sel),
      .core_done     (core_done),
      .core_start    (core_start),
      .core_prog_sel (core_prog_sel),
      .busy          (busy),
      .host_done     (host_done),
      .timeout       (timeout),
      .cycle_count   (cycle_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Expected count after k busy RUN cycles.
   function automatic int model_count(input int k);
      int c;
      c = k;
      if (c > SAT) c = SAT;
      if (WD && (c > TIMEOUT_CYC)) c = TIMEOUT_CYC;
      return c;
   endfunction

   // A run of n busy cycles times out only with the watchdog and n past the limit.
   function automatic bit model_timeout(input int n);
      return WD && (n > TIMEOUT_CYC);
   endfunction

   task automatic test_reset();
      reset = 1'b1; req = 1'b0; prog_sel = 2'd0; core_done = 1'b0;
      #1;
      checks++;
      if ({core_start, busy, host_done, timeout} !== 4'b0000 ||
          core_prog_sel !== 2'd0 || cycle_count !== CNT_W'(0)) begin
         failures++;
         $display("FAIL reset_state: got flags=%b prog=%0d cnt=%0d want 0000/0/0",
                  {core_start, busy, host_done, timeout}, core_prog_sel, cycle_count);
      end
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      checks++;
      if ({core_start, busy, host_done, timeout} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_idle: got flags=%b want 0000", {core_start, busy, host_done, timeout});
      end
   endtask

   // One complete handshake: accept, start pulse, n busy cycles, done, release.
   task automatic run_scenario(input string name, input logic [1:0] ps, input int n,
                               input bit drop, input bit noise);
      int  exp_cnt;
      bit  exp_to;
      exp_to  = model_timeout(n);
      exp_cnt = exp_to ? TIMEOUT_CYC : model_count(n);
      req = 1'b1; prog_sel = ps; core_done = noise;
      @(negedge clock);
      prog_sel = ~ps;
      for (int i = 0; i < START_W; i++) begin
         checks++;
         if ({core_start, busy, host_done, timeout} !== 4'b1100) begin
            failures++;
            $display("FAIL %s start_cycle%0d: got flags=%b want 1100", name, i,
                     {core_start, busy, host_done, timeout});
         end
         if (i == 0) begin
            checks++;
            if (core_prog_sel !== ps || cycle_count !== CNT_W'(0)) begin
               failures++;
               $display("FAIL %s accept: got prog=%0d cnt=%0d want prog=%0d cnt=0",
                        name, core_prog_sel, cycle_count, ps);
            end
         end
         if (drop) req = 1'b0;
         core_done = noise ? 1'($urandom_range(0, 1)) : 1'b0;
         @(negedge clock);
      end
      checks++;
      if ({core_start, busy, host_done, timeout} !== 4'b0100 || cycle_count !== CNT_W'(0)) begin
         failures++;
         $display("FAIL %s run_entry: got flags=%b cnt=%0d want 0100 cnt=0", name,
                  {core_start, busy, host_done, timeout}, cycle_count);
      end
      for (int k = 0; k < n; k++) begin
         core_done = 1'b0;
         @(negedge clock);
         checks++;
         if (cycle_count !== CNT_W'(model_count(k + 1)) ||
             busy !== !model_timeout(k + 1)) begin
            failures++;
            $display("FAIL %s run_cycle%0d: got cnt=%0d busy=%b want cnt=%0d busy=%b", name,
                     k + 1, cycle_count, busy, model_count(k + 1), !model_timeout(k + 1));
         end
         if (model_timeout(k + 1)) break;
      end
      if (!exp_to) begin
         core_done = 1'b1;
         @(negedge clock);
      end
      core_done = noise;
      req = 1'b1;
      checks++;
      if ({core_start, busy, host_done, timeout} !== {3'b001, exp_to} ||
          cycle_count !== CNT_W'(exp_cnt) || core_prog_sel !== ps) begin
         failures++;
         $display("FAIL %s finish: got flags=%b cnt=%0d prog=%0d want %b cnt=%0d prog=%0d", name,
                  {core_start, busy, host_done, timeout}, cycle_count, core_prog_sel,
                  {3'b001, exp_to}, exp_cnt, ps);
      end
      for (int h = 0; h < 2; h++) begin
         @(negedge clock);
         checks++;
         if ({core_start, busy, host_done, timeout} !== {3'b001, exp_to} ||
             cycle_count !== CNT_W'(exp_cnt)) begin
            failures++;
            $display("FAIL %s hold%0d: got flags=%b cnt=%0d want %b cnt=%0d", name, h,
                     {core_start, busy, host_done, timeout}, cycle_count,
                     {3'b001, exp_to}, exp_cnt);
         end
      end
      req = 1'b0;
      @(negedge clock);
      core_done = noise;
      for (int j = 0; j < 2; j++) begin
         checks++;
         if ({core_start, busy, host_done, timeout} !== 4'b0000 ||
             cycle_count !== CNT_W'(exp_cnt) || core_prog_sel !== ps) begin
            failures++;
            $display("FAIL %s idle%0d: got flags=%b cnt=%0d prog=%0d want 0000 cnt=%0d prog=%0d",
                     name, j, {core_start, busy, host_done, timeout}, cycle_count,
                     core_prog_sel, exp_cnt, ps);
         end
         @(negedge clock);
      end
      core_done = 1'b0;
   endtask

   task automatic test_basic();
      run_scenario("basic", 2'd2, 9, 1'b0, 1'b0);
   endtask

   task automatic test_watchdog();
      run_scenario("watchdog", 2'd1, 20, 1'b0, 1'b0);
   endtask

   task automatic test_done_wins();
      run_scenario("done_wins", 2'd3, TIMEOUT_CYC, 1'b0, 1'b0);
   endtask

   task automatic test_back_to_back();
      run_scenario("b2b_a", 2'd0, 3, 1'b1, 1'b1);
      run_scenario("b2b_b", 2'd3, 0, 1'b0, 1'b1);
   endtask

   // Reset asserted between edges, a given number of cycles after acceptance.
   task automatic test_reset_mid(input string name, input int cycles);
      req = 1'b1; prog_sel = 2'd3; core_done = 1'b0;
      @(negedge clock);
      req = 1'b0;
      repeat (cycles) @(negedge clock);
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({core_start, busy, host_done, timeout} !== 4'b0000 ||
          core_prog_sel !== 2'd0 || cycle_count !== CNT_W'(0)) begin
         failures++;
         $display("FAIL %s async_clear: got flags=%b prog=%0d cnt=%0d want 0000/0/0", name,
                  {core_start, busy, host_done, timeout}, core_prog_sel, cycle_count);
      end
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      run_scenario(name, 2'd1, 4, 1'b0, 1'b0);
   endtask

   task automatic test_random();
      for (int r = 0; r < 25; r++) begin
         run_scenario("random", 2'($urandom_range(0, 3)), int'($urandom_range(0, 20)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_watchdog();
      test_done_wins();
      test_back_to_back();
      test_reset_mid("reset_mid_run", START_W + 3);
      test_reset_mid("reset_mid_start", 1);
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/run_sequencer.md
RUN_SEQUENCER -- requirements
Module: run_sequencer

Interface
REQ-001 SHALL have parameter START_W, default 2, the number of cycles core_start is held high per run (legal range 1..15).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 4096, the watchdog limit in RUN cycles (legal range 1..2^CNT_W-2).
REQ-003 SHALL have parameter CNT_W, default 16, the width of cycle_count.
REQ-004 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port req, input, 1 bit: host run request, 4-phase level handshake.
REQ-007 SHALL have port prog_sel, input, 2 bits: program select, sampled only on acceptance.
REQ-008 SHALL have port core_done, input, 1 bit: the core's done output.
REQ-009 SHALL have port core_start, output, 1 bit: drives the core's start input.
REQ-010 SHALL have port core_prog_sel, output, 2 bits: latched program select presented to the core.
REQ-011 SHALL have port busy, output, 1 bit: high in START and RUN.
REQ-012 SHALL have port host_done, output, 1 bit: high in DONE and TIMEOUT.
REQ-013 SHALL have port timeout, output, 1 bit: high in TIMEOUT only.
REQ-014 SHALL have port cycle_count, output, CNT_W bits: count of RUN cycles for the current or last run.

Function
REQ-015 SHALL implement states IDLE, START, RUN, DONE, TIMEOUT; all outputs registered or decoded from the state register only.
REQ-016 IDLE with req=1 at edge k SHALL latch prog_sel into core_prog_sel, clear cycle_count, and enter START, so core_start=1 from edge k.
REQ-017 START SHALL hold core_start=1 for exactly START_W cycles, then enter RUN with core_start=0.
REQ-018 RUN SHALL increment cycle_count on each edge where core_done=0, saturating at all-ones.
REQ-019 RUN with core_done=1 SHALL enter DONE on that edge, with cycle_count frozen.
REQ-020 DONE and TIMEOUT SHALL hold their outputs until req=0 is sampled, then enter IDLE; host_done falls on that edge.
REQ-021 Deassertion of req during START or RUN SHALL be ignored; the run completes.
REQ-022 core_done SHALL be ignored outside RUN, including while core_start=1.
REQ-023 cycle_count and core_prog_sel SHALL retain their last values in DONE, TIMEOUT and IDLE until the next acceptance.
REQ-024 req held high after host_done SHALL NOT start a new run; IDLE must be re-entered first.

Reset
REQ-025 Reset SHALL force IDLE asynchronously, with core_start=0, busy=0, host_done=0, timeout=0, core_prog_sel=0, cycle_count=0 and the START counter=0, including during a run.

Configuration
REQ-026 With macro RUN_SEQUENCER_WATCHDOG_EN defined, RUN SHALL enter TIMEOUT when cycle_count==TIMEOUT_CYC and core_done=0; on a simultaneous core_done=1, DONE wins.
REQ-027 With RUN_SEQUENCER_WATCHDOG_EN undefined, TIMEOUT SHALL be unreachable and omitted, timeout SHALL be tied to 0, and TIMEOUT_CYC SHALL be unused.

Structure
REQ-028 Package run_seq_pkg SHALL hold the state enum type and the default START_W, TIMEOUT_CYC and CNT_W constants.
REQ-029 The saturating counter with clear and enable SHALL be sub-module sat_counter, parameterised by width.

Verification
REQ-030 Reset, then req=1 with prog_sel=2 -> core_prog_sel=2; core_start high for exactly 2 cycles; busy=1.
REQ-031 core_done raised on the 10th RUN cycle -> cycle_count=9, host_done=1; after req=0, IDLE with cycle_count still 9.
REQ-032 WATCHDOG_EN with TIMEOUT_CYC=8 and core_done never raised -> timeout=1, host_done=1, cycle_count=8; without the macro, busy stays 1.
REQ-033 core_done=1 on the same edge as cycle_count==TIMEOUT_CYC -> DONE, timeout=0.
REQ-034 Reset asserted mid-RUN -> all outputs 0 immediately (before the next edge); a new req is then accepted normally.
REQ-035 req held high through DONE -> no second core_start pulse until req=0 then req=1; core_done pulses in IDLE and DONE are ignored.
